// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - framed LSB-first serial transmitter: start, data, parity, stop
module parity_frame_tx #(
  parameter int DATA_W       = 4,
  parameter bit ODD_PARITY   = 1'b0,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              parity_bit,
  output logic              frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              accept;
  logic              bit_end;
  logic              last_bit;

  assign accept   = in_valid && (state == IDLE);
  assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_cnt == BW'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)              state_nxt = START;
      START:   if (bit_end)             state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = PARITY;
      PARITY:  if (bit_end)             state_nxt = STOP;
      STOP:    if (bit_end)             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Bit timing, data shifter and parity latch; the shifter only moves inside DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      if (state == IDLE || bit_end) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + CW'(1);

      if (state != DATA)                clk_cnt_hold_bits: bit_cnt <= '0;
      else if (bit_end)                 bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);

      if (accept) begin
        shift      <= in_data;
        parity_bit <= (^in_data) ^ ODD_PARITY;
      end else if (state == DATA && bit_end) begin
        shift <= shift >> 1;
      end
    end
  end

  always_comb begin
    tx_line    = 1'b1;
    in_ready   = 1'b0;
    tx_busy    = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        tx_busy  = 1'b0;
      end
      START:   tx_line = 1'b0;
      DATA:    tx_line = shift[0];
      PARITY:  tx_line = parity_bit;
      STOP:    frame_done = bit_end;
      default: tx_busy = 1'b0;
    endcase
  end

endmodule
